// File: rtl/lane_scheduler_pkg.sv
// Shared constants for the two-lane round-robin scheduler.
package lane_scheduler_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_AW    = 2;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/lane_scheduler_fifo.sv
// Small synchronous FIFO with a combinational head read.
// A push into a full FIFO is ignored even if a pop happens on the same edge.
module sched_fifo
    import lane_scheduler_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lane_scheduler.sv
// Round-robin merge of two buffered input lanes onto one registered
// valid/ready output lane.
module lane_scheduler
    import lane_scheduler_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    input  logic       ready_out,
    output logic       full_0,
    output logic       full_1,
    output logic       overflow_0,
    output logic       overflow_1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_out
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_data;
    logic       r_lane;
    logic       r_last_grant;
    logic       r_ovf_0;
    logic       r_ovf_1;

    logic       w_empty_0;
    logic       w_empty_1;
    logic [7:0] w_head_0;
    logic [7:0] w_head_1;
    logic [7:0] w_head;
    logic       w_any;
    logic       w_grant;
    logic       w_load;
    logic       w_pop_0;
    logic       w_pop_1;

    sched_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_0 (
        .clk   (clk8f),
        .rst_n (reset),
        .push  (valid_in_0),
        .pop   (w_pop_0),
        .din   (data_in_0),
        .dout  (w_head_0),
        .full  (full_0),
        .empty (w_empty_0)
    );

    sched_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_1 (
        .clk   (clk8f),
        .rst_n (reset),
        .push  (valid_in_1),
        .pop   (w_pop_1),
        .din   (data_in_1),
        .dout  (w_head_1),
        .full  (full_1),
        .empty (w_empty_1)
    );

    assign w_any  = !w_empty_0 || !w_empty_1;
    assign w_head = (w_grant == LANE1) ? w_head_1 : w_head_0;

    // Arbitration: a lone non-empty lane wins; under contention the lane
    // that did not win last time gets the slot.
    always_comb begin
        w_grant = LANE0;
        if (!w_empty_0 && !w_empty_1) begin
            w_grant = ~r_last_grant;
        end else if (!w_empty_0) begin
            w_grant = LANE0;
        end else if (!w_empty_1) begin
            w_grant = LANE1;
        end
    end

    // Next state and load decision; a load always pops the granted lane.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = SEND;
                    w_load       = 1'b1;
                end
            end
            SEND: begin
                if (ready_out) begin
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_pop_0 = w_load && (w_grant == LANE0);
    assign w_pop_1 = w_load && (w_grant == LANE1);

    // State register.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output word register and round-robin history; last_grant resets to
    // lane 1 so lane 0 takes the first contested slot.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_data       <= 8'h00;
            r_lane       <= LANE0;
            r_last_grant <= LANE1;
        end else if (w_load) begin
            r_data       <= w_head;
            r_lane       <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    // Sticky drop flags: a valid word arriving at a full FIFO is lost.
    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_ovf_0 <= 1'b0;
            r_ovf_1 <= 1'b0;
        end else begin
            if (valid_in_0 && full_0) begin
                r_ovf_0 <= 1'b1;
            end
            if (valid_in_1 && full_1) begin
                r_ovf_1 <= 1'b1;
            end
        end
    end

    assign data_out   = r_data;
    assign lane_out   = r_lane;
    assign valid_out  = (r_state == SEND);
    assign overflow_0 = r_ovf_0;
    assign overflow_1 = r_ovf_1;

endmodule
